nco_freq_meter: RTL and testbench

//   Measures an NCO output stream: counts rising edges of sample_in[7] over a fixed

---
 rtl/nco_freq_meter.sv | 160 ++++++++++++++++
 tb/tb_nco_freq_meter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_freq_meter.sv
// nco_freq_meter
//   Reader for an NCO sample stream. It counts rising edges of the sample MSB
//   (the half-phase bit) over a gate window of 2^GATE_LOG2 clocks and reports
//   the count together with the last rise-to-rise distance seen in that window.
//   Use it to check that edge_count ~= tuning_word * 2^GATE_LOG2 / 2^phase_width.
//
// Ports
//   clk         clock (single domain)
//   rst         asynchronous, active-high reset
//   enable      block enable; low aborts a window in progress
//   start       level-sampled; starts a window from IDLE when enable=1
//   continuous  1: back-to-back windows until cleared
//   sample_in   NCO sample; only bit 7 is used
//   edge_count  MSB rising edges counted in the last completed window
//   period      last rise-to-rise distance in that window; 0 if fewer than 2 rises
//   valid       one-cycle pulse: edge_count/period were just updated
//   busy        high while a window is being counted
module nco_freq_meter #(
  parameter int unsigned GATE_LOG2 = 8,
  parameter int unsigned CNT_W     = GATE_LOG2,
  parameter int unsigned PER_W     = GATE_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             continuous,
  input  logic [7:0]       sample_in,
  output logic [CNT_W-1:0] edge_count,
  output logic [PER_W-1:0] period,
  output logic             valid,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 msb_q, msb_d;
  logic [GATE_LOG2-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]     acc_q, acc_d;
  logic [PER_W-1:0]     since_rise_q, since_rise_d;
  logic                 seen_q, seen_d;
  logic [PER_W-1:0]     period_acc_q, period_acc_d;
  logic [CNT_W-1:0]     edge_count_q, edge_count_d;
  logic [PER_W-1:0]     period_q, period_d;
  logic                 valid_q, valid_d;

  logic                 rise;
  logic                 last_cycle;
  logic [PER_W-1:0]     final_period;

  // Low sample bits carry the fine phase and are intentionally ignored.
  logic                 unused_low_bits;
  assign unused_low_bits = ^sample_in[6:0];

  assign rise       = sample_in[7] & ~msb_q;
  assign last_cycle = (gate_cnt_q == '1);

  // period_acc is only written once a second rise is seen, so it stays 0
  // for windows with fewer than two rises; a rise on the last cycle is
  // folded in here so the latched value includes it.
  assign final_period = (rise && seen_q) ? (since_rise_q + PER_W'(1)) : period_acc_q;

  always_comb begin
    state_d      = state_q;
    msb_d        = sample_in[7];
    gate_cnt_d   = gate_cnt_q;
    acc_d        = acc_q;
    since_rise_d = since_rise_q;
    seen_d       = seen_q;
    period_acc_d = period_acc_q;
    edge_count_d = edge_count_q;
    period_d     = period_q;
    valid_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        gate_cnt_d   = '0;
        acc_d        = '0;
        since_rise_d = '0;
        seen_d       = 1'b0;
        period_acc_d = '0;
        if (start && enable) begin
          state_d = COUNT;
        end
      end

      COUNT: begin
        if (!enable) begin
          // Abort: results from the previous window are left untouched.
          state_d = IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_LOG2'(1);
          if (rise) begin
            acc_d        = acc_q + CNT_W'(1);
            since_rise_d = '0;
            seen_d       = 1'b1;
            if (seen_q) begin
              period_acc_d = since_rise_q + PER_W'(1);
            end
          end else begin
            since_rise_d = since_rise_q + PER_W'(1);
          end

          if (last_cycle) begin
            edge_count_d = acc_q + CNT_W'(rise);
            period_d     = final_period;
            valid_d      = 1'b1;
            // Accumulators restart so a continuous run has no gap cycle.
            gate_cnt_d   = '0;
            acc_d        = '0;
            since_rise_d = '0;
            seen_d       = 1'b0;
            period_acc_d = '0;
            if (!continuous) begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      msb_q        <= 1'b0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      since_rise_q <= '0;
      seen_q       <= 1'b0;
      period_acc_q <= '0;
      edge_count_q <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      msb_q        <= msb_d;
      gate_cnt_q   <= gate_cnt_d;
      acc_q        <= acc_d;
      since_rise_q <= since_rise_d;
      seen_q       <= seen_d;
      period_acc_q <= period_acc_d;
      edge_count_q <= edge_count_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
    end
  end

  assign edge_count = edge_count_q;
  assign period     = period_q;
  assign valid      = valid_q;
  assign busy       = (state_q == COUNT);

endmodule

// File: tb/tb_nco_freq_meter.sv
module tb_nco_freq_meter;

  localparam int G     = 8;
  localparam int WIN   = 256;
  localparam int CNT_W = G;
  localparam int PER_W = G + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             start;
  logic             continuous;
  logic [7:0]       sample_in;
  logic [CNT_W-1:0] edge_count;
  logic [PER_W-1:0] period;
  logic             valid;
  logic             busy;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [PER_W-1:0] per;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   edge_cnt = 0;
  int   mode = 0;

  nco_freq_meter #(.GATE_LOG2(G), .CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .start      (start),
    .continuous (continuous),
    .sample_in  (sample_in),
    .edge_count (edge_count),
    .period     (period),
    .valid      (valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Sample source: 0 random, 1 square 8/8, 2 constant 7F, 3 toggle every clock,
  // 4 square 16/16. Low bits are randomised since the DUT must ignore them.
  initial begin
    int ph;
    ph = 0;
    sample_in = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      ph = ph + 1;
      case (mode)
        1:       sample_in = {((ph % 16) < 8), 7'($urandom)};
        2:       sample_in = 8'h7F;
        3:       sample_in = {((ph % 2) == 1), 7'($urandom)};
        4:       sample_in = {((ph % 32) < 16), 7'($urandom)};
        default: sample_in = 8'($urandom);
      endcase
    end
  end

  // Scoreboard monitor: every valid pulse must match the oldest expectation,
  // including the cycle it arrives in. Cycle numbering: the cycle following
  // edge k is cycle k+1.
  always @(negedge clk) begin
    if (!rst && valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid cycle=%0d edge_count=%0d period=%0d",
                 edge_cnt + 1, edge_count, period);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (edge_count !== e.cnt || period !== e.per || (edge_cnt + 1) != e.cyc) begin
          bad++;
          $display("FAIL window_result got cnt=%0d per=%0d cycle=%0d expected cnt=%0d per=%0d cycle=%0d",
                   edge_count, period, edge_cnt + 1, e.cnt, e.per, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; start is sampled on the following edge t0.
  task automatic pulse_start(output int t0);
    start = 1'b1;
    t0 = edge_cnt + 1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mode = 0;
    for (int i = 0; i < 3; i++) begin
      enable     = 1'($urandom);
      start      = 1'($urandom);
      continuous = 1'($urandom);
      tick(1);
      total++;
      if ({edge_count, period, valid, busy} !== '0) begin
        bad++;
        $display("FAIL reset_state got cnt=%0d per=%0d valid=%0b busy=%0b expected all 0",
                 edge_count, period, valid, busy);
      end
    end
    start = 1'b0;
    enable = 1'b1;
    continuous = 1'b0;
    rst = 1'b0;
    tick(5);
    total++;
    if (busy !== 1'b0 || edge_count !== '0 || period !== '0) begin
      bad++;
      $display("FAIL reset_release got busy=%0b cnt=%0d per=%0d expected 0 0 0",
               busy, edge_count, period);
    end
  endtask

  task automatic test_square;
    int t0;
    int n;
    mode = 1;
    tick(2);
    pulse_start(t0);
    sb.push_back('{cnt: CNT_W'(16), per: PER_W'(16), cyc: t0 + WIN + 1});
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL square_busy got %0b expected 1", busy);
    end
    n = 0;
    while (sb.size() > 0 && n < WIN + 20) begin tick(1); n++; end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL square_timeout got pending=%0d expected 0", sb.size());
      sb.delete();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL square_busy_after got %0b expected 0", busy);
    end
  endtask

  task automatic test_const;
    int t0;
    int n;
    mode = 2;
    tick(2);
    pulse_start(t0);
    sb.push_back('{cnt: CNT_W'(0), per: PER_W'(0), cyc: t0 + WIN + 1});
    n = 0;
    while (sb.size() > 0 && n < WIN + 20) begin tick(1); n++; end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL const_timeout got pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_alternating;
    int t0;
    int n;
    mode = 3;
    tick(2);
    pulse_start(t0);
    sb.push_back('{cnt: CNT_W'(128), per: PER_W'(2), cyc: t0 + WIN + 1});
    n = 0;
    while (sb.size() > 0 && n < WIN + 20) begin tick(1); n++; end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL alt_timeout got pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  // start held high with continuous=0: one IDLE cycle between windows.
  task automatic test_back_to_back;
    int t0;
    int n;
    mode = 3;
    tick(2);
    start = 1'b1;
    t0 = edge_cnt + 1;
    sb.push_back('{cnt: CNT_W'(128), per: PER_W'(2), cyc: t0 + WIN + 1});
    sb.push_back('{cnt: CNT_W'(128), per: PER_W'(2), cyc: t0 + 2 * WIN + 2});
    n = 0;
    while (sb.size() > 1 && n < WIN + 20) begin tick(1); n++; end
    start = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < WIN + 20) begin tick(1); n++; end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL b2b_timeout got pending=%0d expected 0", sb.size());
      sb.delete();
    end
    tick(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_busy_after got %0b expected 0", busy);
    end
  endtask

  task automatic test_continuous;
    int t0;
    int n;
    mode = 4;
    tick(2);
    continuous = 1'b1;
    pulse_start(t0);
    for (int k = 0; k < 3; k++)
      sb.push_back('{cnt: CNT_W'(8), per: PER_W'(32), cyc: t0 + (k + 1) * WIN + 1});
    tick(t0 + 2 * WIN + 100 - edge_cnt);
    continuous = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL cont_busy_win3 got %0b expected 1", busy);
    end
    n = 0;
    while (sb.size() > 0 && n < 2 * WIN) begin tick(1); n++; end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL cont_timeout got pending=%0d expected 0", sb.size());
      sb.delete();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_busy_after got %0b expected 0", busy);
    end
    tick(WIN + 50);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_stays_idle got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_abort_and_reset;
    int t0;
    mode = 4;
    tick(2);
    pulse_start(t0);
    tick(t0 + 50 - edge_cnt);
    enable = 1'b0;
    tick(1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy got %0b expected 0", busy);
    end
    tick(WIN + 50);
    total++;
    if (edge_count !== CNT_W'(8) || period !== PER_W'(32)) begin
      bad++;
      $display("FAIL abort_held got cnt=%0d per=%0d expected cnt=8 per=32", edge_count, period);
    end
    enable = 1'b1;
    pulse_start(t0);
    tick(100);
    rst = 1'b1;
    #1;
    total++;
    if ({edge_count, period, valid, busy} !== '0) begin
      bad++;
      $display("FAIL midwin_reset got cnt=%0d per=%0d valid=%0b busy=%0b expected all 0",
               edge_count, period, valid, busy);
    end
    tick(2);
    rst = 1'b0;
    tick(WIN + 20);
    total++;
    if (busy !== 1'b0 || edge_count !== '0 || period !== '0) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%0b cnt=%0d per=%0d expected 0 0 0",
               busy, edge_count, period);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    start = 1'b0;
    continuous = 1'b0;
    test_reset();
    test_square();
    test_const();
    test_alternating();
    test_back_to_back();
    test_continuous();
    test_abort_and_reset();
    tick(2);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expectations got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
